// File: rtl/ser_seq_pkg.sv
// Shared types and constants for the serial word sequencer.
// The state encoding is fixed so that it stays stable across tools and debug views.
package ser_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The hit count must be able to hold WIDTH, so it needs one more code than WIDTH-1.
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_piso.sv
// Parallel-in serial-out shift register. It shifts MSB first and fills with zeros,
// so its output returns to 0 once the whole word has been sent.
module ser_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/serial_word_sequencer.sv
// Feeds each accepted word MSB-first into an external Mealy bit detector.
// It collects the detector's per-bit output as a hit mask plus a popcount.
module serial_word_sequencer
  import ser_seq_pkg::*;
#(
  parameter int  WIDTH      = DEFAULT_WIDTH,
  parameter bit  KEEP_STATE = 1'b0,
  localparam int CW         = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             x_out,
  output logic             det_clr,
  input  logic             y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [CW-1:0]    out_hits
);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             shift_en;
  logic             last_bit;
  logic             ser_msb;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_sel;
  logic [CW-1:0]    hits;

  ser_piso #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .load_data(in_data),
    .msb      (ser_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    det_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        det_clr  = ~KEEP_STATE;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        det_clr   = ~KEEP_STATE;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // The detector is held cleared during reset, even when state is kept across words.
    if (rst) begin
      det_clr = 1'b1;
    end
  end

  // x_out comes only from registers, so in_data has no combinational path to the detector.
  assign x_out = ser_msb & (state == SHIFT);

  always_comb begin
    mask_sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(WIDTH - 1 - i)) begin
        mask_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      mask <= '0;
      hits <= '0;
    end else if (load) begin
      cnt  <= '0;
      mask <= '0;
      hits <= '0;
    end else if (shift_en) begin
      cnt  <= cnt + CW'(1);
      mask <= (mask & ~mask_sel) | (mask_sel & {WIDTH{y_in}});
      hits <= hits + {{(CW-1){1'b0}}, y_in};
    end
  end

  assign out_mask = mask;
  assign out_hits = hits;

endmodule

// File: tb/tb_serial_word_sequencer.sv
// Directed bench for serial_word_sequencer. It uses a "11" detector model and a result scoreboard.
// Instance a clears the detector between words; instance b keeps detector state across words.
module tb_serial_word_sequencer;

  typedef struct packed {
    logic [7:0] mask;
    logic [3:0] hits;
  } res_t;

  logic       clk;
  logic       rst;
  logic       in_valid_a, in_valid_b;
  logic [7:0] in_data_a, in_data_b;
  logic       in_ready_a, in_ready_b;
  logic       x_out_a, x_out_b;
  logic       det_clr_a, det_clr_b;
  logic       y_in_a, y_in_b;
  logic       out_valid_a, out_valid_b;
  logic       out_ready_a, out_ready_b;
  logic [7:0] out_mask_a, out_mask_b;
  logic [3:0] out_hits_a, out_hits_b;

  logic       prev_a, prev_b;
  logic       prev_b_m;
  res_t       sb_a[$];
  res_t       sb_b[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  serial_word_sequencer #(.WIDTH(8), .KEEP_STATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .x_out(x_out_a), .det_clr(det_clr_a), .y_in(y_in_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_mask(out_mask_a), .out_hits(out_hits_a)
  );

  serial_word_sequencer #(.WIDTH(8), .KEEP_STATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .x_out(x_out_b), .det_clr(det_clr_b), .y_in(y_in_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_mask(out_mask_b), .out_hits(out_hits_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // "11" detector: y = previous bit & current bit.
  assign y_in_a = prev_a & x_out_a;
  assign y_in_b = prev_b & x_out_b;

  always @(posedge clk or posedge rst) begin
    if (rst)            prev_a <= 1'b0;
    else if (det_clr_a) prev_a <= 1'b0;
    else                prev_a <= x_out_a;
  end

  // The integrator of b gates the detector so that it only advances on shifted bits.
  always @(posedge clk or posedge rst) begin
    if (rst)                              prev_b <= 1'b0;
    else if (det_clr_b)                   prev_b <= 1'b0;
    else if (!in_ready_b && !out_valid_b) prev_b <= x_out_b;
  end

  function automatic res_t model(input logic [7:0] w, input logic prev_in);
    res_t r;
    logic p;
    r = '0;
    p = prev_in;
    for (int i = 7; i >= 0; i--) begin
      r.mask[i] = p & w[i];
      p = w[i];
    end
    r.hits = 4'($countones(r.mask));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] w);
    int n;
    n = 0;
    in_valid_a = 1'b1;
    in_data_a  = w;
    while (!in_ready_a && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_accept_wait", 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    sb_a.push_back(model(w, 1'b0));
  endtask

  task automatic send_b(input logic [7:0] w);
    int n;
    n = 0;
    in_valid_b = 1'b1;
    in_data_b  = w;
    while (!in_ready_b && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_accept_wait", 32'(in_ready_b), 32'd1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    sb_b.push_back(model(w, prev_b_m));
    prev_b_m = w[0];
    check("b_no_clr_shift", 32'(det_clr_b), 32'd0);
  endtask

  task automatic recv_a(input string tag);
    int   n;
    res_t e;
    n = 0;
    out_ready_a = 1'b1;
    while (!out_valid_a && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid_a), 32'd1);
    if (sb_a.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_a.size()), 32'd1);
    end else begin
      e = sb_a.pop_front();
      check({tag, "_mask"}, 32'(out_mask_a), 32'(e.mask));
      check({tag, "_hits"}, 32'(out_hits_a), 32'(e.hits));
    end
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    check({tag, "_released"}, 32'(out_valid_a), 32'd0);
  endtask

  task automatic recv_b(input string tag);
    int   n;
    res_t e;
    n = 0;
    out_ready_b = 1'b1;
    while (!out_valid_b && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid_b), 32'd1);
    check({tag, "_no_clr"}, 32'(det_clr_b), 32'd0);
    if (sb_b.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_b.size()), 32'd1);
    end else begin
      e = sb_b.pop_front();
      check({tag, "_mask"}, 32'(out_mask_b), 32'(e.mask));
      check({tag, "_hits"}, 32'(out_hits_b), 32'(e.hits));
    end
    @(posedge clk); #1;
    out_ready_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wv;
    logic [7:0] rw;
    int         n_sh;
    int         guard;
    res_t       e;

    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    prev_b_m = 1'b0;
    #2;
    check("rst_in_ready",  32'(in_ready_a),  32'd1);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_x_out",     32'(x_out_a),     32'd0);
    check("rst_det_clr",   32'(det_clr_a),   32'd1);
    check("rst_mask",      32'(out_mask_a),  32'd0);
    check("rst_hits",      32'(out_hits_a),  32'd0);
    check("rst_det_clr_b", 32'(det_clr_b),   32'd1);
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_det_clr_a", 32'(det_clr_a), 32'd1);
    check("idle_det_clr_b", 32'(det_clr_b), 32'd0);

    // Check the bit order on x_out and the latency to out_valid.
    wv = 8'b1101_1110;
    send_a(wv);
    for (int k = 7; k >= 0; k--) begin
      check($sformatf("lat_x_bit%0d", k), 32'(x_out_a), 32'(wv[k]));
      check("lat_not_valid", 32'(out_valid_a), 32'd0);
      check("lat_no_clr", 32'(det_clr_a), 32'd0);
      @(posedge clk); #1;
    end
    check("lat_valid_now", 32'(out_valid_a), 32'd1);
    check("done_x_out", 32'(x_out_a), 32'd0);
    recv_a("w_de");

    send_a(8'h00);
    recv_a("w_00");
    send_a(8'hFF);
    recv_a("w_ff");

    send_b(8'h01);
    recv_b("keep_01");
    send_b(8'hFF);
    recv_b("keep_ff");

    // Hold off the consumer while DONE and present a new word at the same time.
    send_a(8'hB5);
    guard = 0;
    while (!out_valid_a && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid_a = 1'b1;
    in_data_a  = 8'h3C;
    e = sb_a[0];
    repeat (20) begin
      check("bp_valid", 32'(out_valid_a), 32'd1);
      check("bp_ready", 32'(in_ready_a),  32'd0);
      check("bp_mask",  32'(out_mask_a),  32'(e.mask));
      check("bp_hits",  32'(out_hits_a),  32'(e.hits));
      @(posedge clk); #1;
    end
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    void'(sb_a.pop_front());
    check("bp_after_hs_ready", 32'(in_ready_a),  32'd1);
    check("bp_after_hs_valid", 32'(out_valid_a), 32'd0);
    @(posedge clk); #1;
    sb_a.push_back(model(8'h3C, 1'b0));
    in_valid_a = 1'b0;
    check("bp_next_accepted", 32'(in_ready_a), 32'd0);
    recv_a("bp_next");

    // Reset in the 4th SHIFT cycle discards the word in flight.
    send_a(8'hAA);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_shifting", 32'(in_ready_a), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  32'(in_ready_a),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
    check("mid_rst_det_clr",   32'(det_clr_a),   32'd1);
    check("mid_rst_x_out",     32'(x_out_a),     32'd0);
    sb_a.delete();
    prev_b_m = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    send_a(8'b0000_0011);
    recv_a("post_rst");

    // Random out_ready in IDLE and random in_valid during SHIFT must not cause handshakes.
    for (int r = 0; r < 4; r++) begin
      rw = 8'($urandom);
      repeat (4) begin
        out_ready_a = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("rnd_idle_no_valid", 32'(out_valid_a), 32'd0);
        check("rnd_idle_ready",    32'(in_ready_a),  32'd1);
      end
      out_ready_a = 1'b0;
      send_a(rw);
      n_sh  = 0;
      guard = 0;
      while (!out_valid_a && guard < 40) begin
        if (!in_ready_a) n_sh++;
        guard++;
        in_valid_a = 1'($urandom_range(0, 1));
        in_data_a  = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid_a = 1'b0;
      check("rnd_shift_cycles", 32'(n_sh), 32'd8);
      recv_a($sformatf("rnd%0d", r));
    end

    check("sb_a_drained", 32'(sb_a.size()), 32'd0);
    check("sb_b_drained", 32'(sb_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_sequencer.md
Name: serial_word_sequencer

Overview:
- Controller that sequences a single-bit Mealy sequence-detector FSM (x_in/y_out style).
- Accepts parallel words over a valid/ready handshake and shifts each word MSB-first into the detector, one bit per clock.
- Samples the detector's Mealy output on every bit and returns a per-bit hit mask and a hit count over a second valid/ready handshake.
- Sits between a word-oriented producer/consumer and the serial detector.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- KEEP_STATE, 0, 0: detector is held cleared between words; 1: detector state carries across word boundaries.
- CW, derived localparam = $clog2(WIDTH+1), hit-count width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_data  in  WIDTH  word to shift, MSB first.
- in_ready  out  1  sequencer can accept a word.
- x_out  out  1  serial bit to the detector x_in.
- det_clr  out  1  synchronous clear request to the detector; active high.
- y_in  in  1  detector Mealy output (combinational from detector state and x_out).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_mask  out  WIDTH  bit i = y_in sampled while in_data[i] was on x_out.
- out_hits  out  CW  popcount of out_mask.

Behaviour:
- Single clock. Reset is asynchronous and active-high.
- Reset values:
  - FSM = IDLE; in_ready = 1; out_valid = 0; x_out = 0; det_clr = 1.
  - out_mask = 0; out_hits = 0; shift register = 0; bit counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0, x_out = 0.
  - det_clr = 1 if KEEP_STATE = 0, else 0.
  - On in_valid && in_ready: capture in_data into the shift register; clear mask, hits and bit counter to 0; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - in_ready = 0, det_clr = 0.
  - x_out = shreg[WIDTH-1], driven from a register (no combinational path from in_data).
  - Each cycle:
    - mask[WIDTH-1-cnt] <= y_in.
    - hits <= hits + y_in.
    - shreg <<= 1 (zero fill).
    - cnt <= cnt + 1.
  - When cnt == WIDTH-1, go to DONE.
- y_in is sampled in the same cycle x_out carries the bit. The detector advances on the same edge, so the Mealy output is correctly attributed.
- DONE:
  - out_valid = 1; out_mask and out_hits are stable and held.
  - x_out = 0; det_clr as in IDLE.
  - On out_ready: go to IDLE.
  - out_valid is held indefinitely under backpressure; no word is accepted in DONE.
- Latency: word accepted at edge N; bits are on x_out in cycles N+1..N+WIDTH; out_valid is high from the cycle after edge N+WIDTH.
  - Minimum word period = WIDTH + 2 cycles (SHIFT, DONE, IDLE).
- Boundaries:
  - in_valid while not in IDLE: ignored; in_ready = 0, and the producer must hold its word.
  - out_ready while not in DONE: ignored.
  - out_hits saturation cannot occur, since CW covers WIDTH.
  - All-zero word: shifts normally; the result depends only on the detector.
  - KEEP_STATE = 1: det_clr is never asserted after reset release, and the detector sees a continuous bit stream. Idle cycles do not clock bits; the detector sees x = 0 on any idle-cycle edges, which is the integrator's responsibility.
  - rst asserted mid-SHIFT or mid-DONE: immediate return to reset values; the in-flight word and result are discarded.
- No X propagation: out_mask and out_hits are registered, and retain the last result in IDLE.

Decomposition:
- Shared package ser_seq_pkg:
  - state enum {IDLE, SHIFT, DONE} with 2-bit encoding 00/01/10;
  - default WIDTH constant;
  - function for CW.
- One natural sub-module: ser_piso, a WIDTH-bit parallel-in serial-out shift register with load, shift enable and MSB output. The FSM, counters and mask stay in the top module.

Test Plan:
- Use a reference detector model that flags "11": y = 1 when previous bit = 1 and x = 1, with clear to S0. Run WIDTH = 8, KEEP_STATE = 0.
- Word 8'b1101_1110 -> x_out sequence 1,1,0,1,1,1,1,0; out_mask = 8'b0100_1110; out_hits = 4; out_valid asserted 9 cycles after acceptance.
- Word 8'h00 then 8'hFF back-to-back -> 8'hFF gives mask 8'b0111_1111, hits = 7 (det_clr zeroes state between words). With KEEP_STATE = 1 and 8'h01 before 8'hFF -> mask 8'hFF, hits = 8.
- Hold out_ready = 0 for 20 cycles in DONE -> out_valid and result stable, in_ready = 0; a new in_valid is not accepted until one cycle after the out_ready handshake.
- Assert rst at the 4th SHIFT cycle of 8'hAA -> same cycle: in_ready = 1, out_valid = 0, det_clr = 1, x_out = 0; next word 8'b0000_0011 -> mask 8'b0000_0001, hits = 1.
- Toggle out_ready and in_valid randomly in IDLE and SHIFT respectively -> no spurious handshakes; bit counter reaches exactly WIDTH per word (checked by assertion).
